bnn_conv_fold_engine: RTL

//   Binarised conv compute engine, next generation of the folded XNOR-popcount layer.

---
 rtl/bnn_pkg.sv | 39 +++
 rtl/bnn_xnor_popcount.sv | 25 ++
 rtl/bnn_conv_fold_engine.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/bnn_pkg.sv
// Shared helpers and field layout for the binarised conv pipeline (engine, maxpool, config loader).
package bnn_pkg;

  // Engine sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fold_state_e;

  // Threshold word is {pol, th[RES_W-1:0]}; polarity occupies one bit above the threshold
  localparam int unsigned TH_POL_W = 1;

  // Ceiling log2, clog2(1) = 0
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = 32'(i + 1);
    end
    return r;
  endfunction

  // Larger of two values
  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Width of one packed {pol, th} field
  function automatic int unsigned th_field_w(input int unsigned res_w);
    return res_w + TH_POL_W;
  endfunction

  // Bit position of pol inside a {pol, th} field
  function automatic int unsigned th_pol_pos(input int unsigned res_w);
    return res_w;
  endfunction

endpackage

// File: rtl/bnn_xnor_popcount.sv
// Combinational XNOR-popcount of one activation window against one weight row.
module bnn_xnor_popcount
  import bnn_pkg::*;
#(
  parameter int unsigned POP_SIZE = 576,
  parameter int unsigned RES_W    = clog2(POP_SIZE + 1)
) (
  input  logic [POP_SIZE-1:0] i_win,
  input  logic [POP_SIZE-1:0] i_w,
  output logic [RES_W-1:0]    o_pop_c
);

  logic [POP_SIZE-1:0] w_match;

  assign w_match = ~(i_win ^ i_w);

  // Count matching bit positions
  always_comb begin
    o_pop_c = '0;
    for (int i = 0; i < int'(POP_SIZE); i++) begin
      o_pop_c = o_pop_c + RES_W'(w_match[i]);
    end
  end

endmodule

// File: rtl/bnn_conv_fold_engine.sv
// Folded binarised conv engine: one window in, CH_OUT thresholded bits out after FOLD passes.
module bnn_conv_fold_engine
  import bnn_pkg::*;
#(
  parameter  int unsigned CH_IN       = 64,
  parameter  int unsigned K_S         = 3,
  parameter  int unsigned CH_OUT      = 64,
  parameter  int unsigned FOLD        = 4,
  localparam int unsigned CH_OUT_FOLD = CH_OUT / FOLD,
  localparam int unsigned POP_SIZE    = K_S * K_S * CH_IN,
  localparam int unsigned RES_W       = clog2(POP_SIZE + 1),
  localparam int unsigned AW          = max2(1, clog2(FOLD)),
  localparam int unsigned TH_W        = th_field_w(RES_W)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [POP_SIZE-1:0]           win_data,
  input  logic                          win_valid,
  output logic                          win_ready,
  input  logic                          cfg_w_we,
  input  logic [AW-1:0]                 cfg_w_addr,
  input  logic [POP_SIZE*CH_OUT_FOLD-1:0] cfg_w_data,
  input  logic                          cfg_th_we,
  input  logic [AW-1:0]                 cfg_th_addr,
  input  logic [TH_W*CH_OUT_FOLD-1:0]   cfg_th_data,
  output logic [CH_OUT-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int unsigned WROW_W  = POP_SIZE * CH_OUT_FOLD;
  localparam int unsigned THROW_W = TH_W * CH_OUT_FOLD;
  localparam int unsigned POL_POS = th_pol_pos(RES_W);

  fold_state_e r_state;
  fold_state_e w_state_next;
  logic        r_out_valid;
  logic        w_out_valid_next;

  logic [AW-1:0]          r_fold_cnt;
  logic [POP_SIZE-1:0]    r_win;
  logic [CH_OUT-1:0]      r_acc;
  logic [WROW_W-1:0]      r_wmem  [FOLD];
  logic [THROW_W-1:0]     r_thmem [FOLD];
  logic [WROW_W-1:0]      w_wrow;
  logic [THROW_W-1:0]     w_throw;
  logic [CH_OUT_FOLD-1:0] w_bits;
  logic                   w_accept;
  logic                   w_last;

  // Ready straight from registered state; a draining DONE can take the next window
  assign win_ready = ~reset & ((r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready));
  assign w_accept  = win_valid & win_ready;
  assign w_last    = (r_fold_cnt == AW'(FOLD - 1));
  assign out_valid = r_out_valid;
  assign out_data  = r_acc;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_out_valid <= w_out_valid_next;
    end
  end

  // Next state and registered-output intent
  always_comb begin
    w_state_next     = r_state;
    w_out_valid_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_next     = ST_DONE;
          w_out_valid_next = 1'b1;
        end
      end
      ST_DONE: begin
        w_out_valid_next = 1'b1;
        if (out_ready) begin
          w_out_valid_next = 1'b0;
          w_state_next     = w_accept ? ST_RUN : ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Fold counter and result accumulator
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fold_cnt <= '0;
      r_acc      <= '0;
    end else if (w_accept) begin
      r_fold_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_acc[32'(r_fold_cnt) * CH_OUT_FOLD +: CH_OUT_FOLD] <= w_bits;
      r_fold_cnt <= w_last ? '0 : r_fold_cnt + AW'(1);
    end
  end

  // Window capture on accept only
  always_ff @(posedge clk) begin
    if (w_accept) r_win <= win_data;
  end

  // Weight/threshold memories: async read at fold_cnt, single write port each
  if (FOLD == 1) begin : g_one
    logic w_unused_addr;
    assign w_unused_addr = ^{cfg_w_addr, cfg_th_addr};
    assign w_wrow  = r_wmem[0];
    assign w_throw = r_thmem[0];

    // Single-slot config write, address ignored
    always_ff @(posedge clk) begin
      if (cfg_w_we)  r_wmem[0]  <= cfg_w_data;
      if (cfg_th_we) r_thmem[0] <= cfg_th_data;
    end
  end else begin : g_many
    logic w_w_ok;
    logic w_th_ok;
    if (FOLD == (1 << AW)) begin : g_pow2
      assign w_w_ok  = 1'b1;
      assign w_th_ok = 1'b1;
    end else begin : g_npow2
      assign w_w_ok  = (32'(cfg_w_addr)  < FOLD);
      assign w_th_ok = (32'(cfg_th_addr) < FOLD);
    end
    assign w_wrow  = r_wmem[r_fold_cnt];
    assign w_throw = r_thmem[r_fold_cnt];

    // Addressed config write, out-of-range slots dropped
    always_ff @(posedge clk) begin
      if (cfg_w_we  && w_w_ok)  r_wmem[cfg_w_addr]   <= cfg_w_data;
      if (cfg_th_we && w_th_ok) r_thmem[cfg_th_addr] <= cfg_th_data;
    end
  end

  // Processing elements: popcount then polarity-selected threshold compare
  for (genvar p = 0; p < int'(CH_OUT_FOLD); p++) begin : g_pe
    logic [RES_W-1:0] w_pop;
    logic [RES_W-1:0] w_th;
    logic             w_pol;

    assign w_th  = w_throw[p*TH_W +: RES_W];
    assign w_pol = w_throw[p*TH_W + POL_POS];

    bnn_xnor_popcount #(
      .POP_SIZE (POP_SIZE),
      .RES_W    (RES_W)
    ) u_pop (
      .i_win   (r_win),
      .i_w     (w_wrow[p*POP_SIZE +: POP_SIZE]),
      .o_pop_c (w_pop)
    );

    assign w_bits[p] = w_pol ? (w_pop > w_th) : (w_pop <= w_th);
  end

endmodule
